// File: rtl/mem_copy_engine.sv
// Word-granular memory copy/fill engine: one command at a time, COPY alternates
// READ/WRITE per word, FILL streams consecutive WRITE cycles.
module mem_copy_engine #(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [15:0]          cmd_src,
    input  logic [15:0]          cmd_dst,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [15:0]          cmd_fill_data,
    output logic [15:0]          mem_access_addr,
    output logic                 mem_write_en,
    output logic [15:0]          mem_write_data,
    input  logic [15:0]          mem_read_data,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] words_done
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    typedef struct packed {
        logic                 op;
        logic [15:0]          src;
        logic [15:0]          dst;
        logic [LEN_WIDTH-1:0] len;
        logic [15:0]          fill;
    } cmd_t;

    localparam logic OP_FILL = 1'b1;

    state_t               state, state_nxt;
    cmd_t                 cmd;
    logic [15:0]          data_q;
    logic [LEN_WIDTH-1:0] words_done_q;
    logic                 accept;
    logic                 last_word;

    assign accept = cmd_valid && (state == IDLE);

    // One extra bit so the last-word compare cannot wrap at the maximum length.
    assign last_word = ({1'b0, words_done_q} + {{LEN_WIDTH{1'b0}}, 1'b1}) == {1'b0, cmd.len};

    always_comb begin
        state_nxt       = state;
        cmd_ready       = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        mem_access_addr = 16'h0000;
        mem_write_en    = 1'b0;
        mem_write_data  = 16'h0000;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    if (cmd_len == '0)
                        state_nxt = DONE;
                    else if (cmd_op == OP_FILL)
                        state_nxt = WRITE;
                    else
                        state_nxt = READ;
                end
            end
            READ: begin
                mem_access_addr = cmd.src;
                state_nxt       = WRITE;
            end
            WRITE: begin
                mem_access_addr = cmd.dst;
                mem_write_en    = 1'b1;
                mem_write_data  = (cmd.op == OP_FILL) ? cmd.fill : data_q;
                if (last_word)
                    state_nxt = DONE;
                else if (cmd.op != OP_FILL)
                    state_nxt = READ;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cmd          <= '0;
            data_q       <= 16'h0000;
            words_done_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd.op       <= cmd_op;
                cmd.src      <= cmd_src;
                cmd.dst      <= cmd_dst;
                cmd.len      <= cmd_len;
                cmd.fill     <= cmd_fill_data;
                words_done_q <= '0;
            end
            if (state == READ)
                data_q <= mem_read_data;
            if (state == WRITE) begin
                cmd.src      <= cmd.src + 16'd1;
                cmd.dst      <= cmd.dst + 16'd1;
                words_done_q <= words_done_q + 1'b1;
            end
        end
    end

    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: directed and random commands against a word-array
// reference model of the copy/fill rules.
module tb_mem_copy_engine;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [15:0]   cmd_src = '0;
    logic [15:0]   cmd_dst = '0;
    logic [LW-1:0] cmd_len = '0;
    logic [15:0]   cmd_fill_data = '0;
    logic [15:0]   mem_access_addr;
    logic          mem_write_en;
    logic [15:0]   mem_write_data;
    logic [15:0]   mem_read_data;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_done;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [31:0] wlog[$];
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_fill_data(cmd_fill_data),
        .mem_access_addr(mem_access_addr), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy), .done(done), .words_done(words_done)
    );

    assign mem_read_data = mem[mem_access_addr];

    always @(posedge clk) begin
        if (mem_write_en === 1'b1) begin
            mem[mem_access_addr] <= mem_write_data;
            wlog.push_back({mem_access_addr, mem_write_data});
        end
    end

    function automatic int exp_latency(input logic op, input int len);
        if (len == 0) return 1;
        return op ? len + 1 : 2 * len + 1;
    endfunction

    // Reference: words processed in ascending order, each read sees earlier writes.
    task automatic model(input logic op, input logic [15:0] src, input logic [15:0] dst,
                         input int len, input logic [15:0] fill);
        for (int i = 0; i < len; i++) begin
            logic [15:0] sa, da, d;
            sa = src + 16'(i);
            da = dst + 16'(i);
            d  = op ? fill : ref_mem[sa];
            ref_mem[da] = d;
            exp_q.push_back({da, d});
        end
    endtask

    task automatic issue(input logic op, input logic [15:0] src, input logic [15:0] dst,
                         input logic [LW-1:0] len, input logic [15:0] fill, input bit rel);
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_fill_data = fill;
        cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL issue_ready: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // Scramble inputs so any use of unlatched command fields shows up.
        cmd_op = 1'($urandom); cmd_src = 16'($urandom); cmd_dst = 16'($urandom);
        cmd_len = LW'($urandom); cmd_fill_data = 16'($urandom);
        checks++;
        if (words_done !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_state: words_done=%0d busy=%b required 0 and 1", words_done, busy);
        end
    endtask

    task automatic finish_cmd(input string name, input int exp_lat, input logic [LW-1:0] len,
                              input bit hold);
        int n;
        bit seen;
        n = 1; seen = 0;
        while (!seen && n <= 1000) begin
            @(negedge clk);
            checks++;
            if (mem_write_en !== 1'b1 && mem_write_data !== 16'h0) begin
                errors++;
                $display("FAIL %s idle_wdata: mem_write_data=%h required 0", name, mem_write_data);
            end
            if (hold) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL %s hold_ready: cmd_ready=%b required 0", name, cmd_ready);
                end
            end
            if (done === 1'b1) seen = 1;
            else n++;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: no done within %0d cycles", name, n);
            return;
        end
        if (n != exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d required %0d", name, n, exp_lat);
        end
        checks++;
        if (words_done !== len || mem_access_addr !== 16'h0 || mem_write_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done_cycle: words_done=%0d addr=%h we=%b busy=%b required %0d 0000 0 1",
                     name, words_done, mem_access_addr, mem_write_en, busy, len);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || words_done !== len || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b words_done=%0d ready=%b busy=%b required 0 %0d 1 0",
                     name, done, words_done, cmd_ready, busy, len);
        end
    endtask

    task automatic check_writes(input string name);
        int bad;
        bad = 0;
        checks++;
        if (wlog.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, wlog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++)
                if (wlog[i] !== exp_q[i]) begin
                    if (bad == 0)
                        $display("FAIL %s write[%0d]: addr/data=%h required %h", name, i, wlog[i], exp_q[i]);
                    bad++;
                end
            if (bad != 0) errors++;
        end
        wlog.delete();
        exp_q.delete();
    endtask

    task automatic run(input string name, input logic op, input logic [15:0] src,
                       input logic [15:0] dst, input logic [LW-1:0] len, input logic [15:0] fill);
        model(op, src, dst, int'(len), fill);
        issue(op, src, dst, len, fill, 1'b0);
        finish_cmd(name, exp_latency(op, int'(len)), len, 1'b0);
        check_writes(name);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_write_en !== 1'b0 ||
            mem_access_addr !== 16'h0 || mem_write_data !== 16'h0 || words_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b busy=%b done=%b we=%b addr=%h wd=%h words=%0d",
                     cmd_ready, busy, done, mem_write_en, mem_access_addr, mem_write_data, words_done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_copy_basic();
        mem[16'h10] = 16'h00A1; ref_mem[16'h10] = 16'h00A1;
        mem[16'h11] = 16'h00B2; ref_mem[16'h11] = 16'h00B2;
        mem[16'h12] = 16'h00C3; ref_mem[16'h12] = 16'h00C3;
        run("copy_basic", 1'b0, 16'h0010, 16'h0040, 8'd3, 16'h0);
    endtask

    task automatic test_fill_basic();
        run("fill_basic", 1'b1, 16'h0000, 16'h0020, 8'd4, 16'hBEEF);
    endtask

    task automatic test_len_zero();
        run("copy_len0", 1'b0, 16'h0100, 16'h0200, 8'd0, 16'h0);
        run("fill_len0", 1'b1, 16'h0100, 16'h0200, 8'd0, 16'h1234);
    endtask

    task automatic test_wrap();
        run("fill_wrap", 1'b1, 16'h0000, 16'hFFFE, 8'd3, 16'h5A5A);
        run("copy_wrap", 1'b0, 16'hFFFD, 16'h0500, 8'd5, 16'h0);
    endtask

    task automatic test_overlap();
        run("copy_overlap_up", 1'b0, 16'h0600, 16'h0601, 8'd6, 16'h0);
        run("copy_overlap_dn", 1'b0, 16'h0701, 16'h0700, 8'd6, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] fill_b;
        fill_b = 16'($urandom);
        model(1'b0, 16'h0800, 16'h0900, 4, 16'h0);
        issue(1'b0, 16'h0800, 16'h0900, 8'd4, 16'h0, 1'b0);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_src = 16'h0; cmd_dst = 16'h0A00;
        cmd_len = 8'd2; cmd_fill_data = fill_b;
        finish_cmd("b2b_first", exp_latency(1'b0, 4), 8'd4, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || words_done !== '0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b words_done=%0d required 1 0", busy, words_done);
        end
        model(1'b1, 16'h0, 16'h0A00, 2, fill_b);
        finish_cmd("b2b_second", exp_latency(1'b1, 2), 8'd2, 1'b0);
        check_writes("b2b");
    endtask

    task automatic test_reset_mid();
        logic [15:0] fill;
        fill = 16'($urandom);
        issue(1'b1, 16'h0, 16'h0B00, 8'd5, fill, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_write_en !== 1'b1 || mem_access_addr !== 16'h0B01) begin
            errors++;
            $display("FAIL rst_mid_phase: we=%b addr=%h required 1 0b01", mem_write_en, mem_access_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || mem_write_en !== 1'b0 ||
            mem_access_addr !== 16'h0 || mem_write_data !== 16'h0 || words_done !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b busy=%b done=%b we=%b addr=%h wd=%h words=%0d",
                     cmd_ready, busy, done, mem_write_en, mem_access_addr, mem_write_data, words_done);
        end
        repeat (3) @(posedge clk);
        #1;
        ref_mem[16'h0B00] = fill;
        exp_q.push_back({16'h0B00, fill});
        check_writes("rst_mid_partial");
        model(1'b0, 16'h0B00, 16'h0C00, 3, 16'h0);
        issue(1'b0, 16'h0B00, 16'h0C00, 8'd3, 16'h0, 1'b1);
        finish_cmd("rst_mid_next", exp_latency(1'b0, 3), 8'd3, 1'b0);
        check_writes("rst_mid_next");
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            logic        op;
            logic [15:0] src, dst, fill;
            logic [LW-1:0] len;
            op   = 1'($urandom);
            src  = 16'($urandom);
            dst  = (k % 3 == 0) ? src + 16'($urandom_range(1, 3)) : 16'($urandom);
            len  = LW'($urandom_range(0, 24));
            fill = 16'($urandom);
            run($sformatf("random%0d", k), op, src, dst, len, fill);
        end
    endtask

    task automatic test_max_len();
        run("copy_max", 1'b0, 16'hFF80, 16'h2000, 8'hFF, 16'h0);
        run("fill_max", 1'b1, 16'h0, 16'hFFF0, 8'hFF, 16'hC0DE);
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL memory_image: %0d words differ, required 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        test_reset();
        test_copy_basic();
        test_fill_basic();
        test_len_zero();
        test_wrap();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_max_len();
        test_memory_image();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 8, width of cmd_len and the word counter.
REQ-002 SHALL have ports clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 SHALL have ports cmd_valid input 1, command offered; cmd_ready output 1, engine idle and accepting.
REQ-004 SHALL have port cmd_op input 1: 0 = COPY, 1 = FILL.
REQ-005 SHALL have ports cmd_src input 16, COPY source word address; cmd_dst input 16, destination word address.
REQ-006 SHALL have ports cmd_len input LEN_WIDTH, word count; cmd_fill_data input 16, FILL pattern.
REQ-007 SHALL have ports mem_access_addr output 16, memory word address; mem_write_en output 1, write strobe; mem_write_data output 16, write data.
REQ-008 SHALL have port mem_read_data input 16, combinational read data for mem_access_addr, valid in the same cycle.
REQ-009 SHALL have ports busy output 1, command in progress; done output 1, one-cycle completion pulse; words_done output LEN_WIDTH, words written for the current command.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-011 SHALL drive cmd_ready = 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-012 SHALL latch cmd_op, src, dst, len and fill_data on acceptance; later input changes have no effect until the next acceptance.
REQ-013 SHALL transition on acceptance to DONE if len = 0, else to READ for COPY, else to WRITE for FILL.
REQ-014 READ: SHALL drive mem_access_addr = current src, mem_write_en = 0, capture mem_read_data into a data register at the edge, then go to WRITE.
REQ-015 WRITE: SHALL drive mem_access_addr = current dst, mem_write_en = 1, mem_write_data = captured word (COPY) or fill_data (FILL).
REQ-016 At each WRITE edge: SHALL increment src, dst and words_done; if words_done+1 = len, go to DONE; else go to READ (COPY) or stay in WRITE (FILL).
REQ-017 Addresses SHALL increment modulo 2^16, so 0xFFFF wraps to 0x0000 with no error.
REQ-018 COPY SHALL proceed in ascending address order; overlapping ranges with dst > src overwrite source words before they are read, and this is accepted behaviour.
REQ-019 DONE: SHALL assert done = 1 for exactly one cycle, then go to IDLE; words_done SHALL hold its final value until the next acceptance, when it clears to 0.
REQ-020 busy SHALL be 1 in READ, WRITE and DONE, and 0 in IDLE.
REQ-021 Outside WRITE, mem_write_en SHALL be 0 and mem_write_data SHALL be 0.
REQ-022 In IDLE and DONE, mem_access_addr SHALL be 0.
REQ-023 Latency from the acceptance edge to the done cycle SHALL be 2*len+1 cycles for COPY, len+1 for FILL, and 1 for len = 0.
REQ-024 A command offered while busy SHALL be held off by cmd_ready = 0 and accepted in the first IDLE cycle after DONE.
REQ-025 Maximum len SHALL be 2^LEN_WIDTH-1; len arithmetic SHALL NOT wrap.

Reset
REQ-026 While rst_n = 0, SHALL immediately force state = IDLE, cmd_ready = 1, busy = 0, done = 0, mem_write_en = 0, mem_access_addr = 0, mem_write_data = 0, words_done = 0, and clear all internal registers.
REQ-027 Reset mid-command SHALL abandon the command at once; no further write strobe occurs, and the partially written destination is left as is.
REQ-028 After rst_n rises, the first command SHALL be acceptable on the first rising edge.

Verification
REQ-029 COPY src=0x10, dst=0x40, len=3, memory[0x10..0x12] = A1,B2,C3 -> three write strobes at 0x40..0x42 carrying A1,B2,C3; done 7 cycles after acceptance; words_done = 3.
REQ-030 FILL dst=0x20, len=4, fill_data=0xBEEF -> consecutive strobes at 0x20..0x23; done 5 cycles after acceptance.
REQ-031 COPY len=0 -> no mem_write_en; done in the cycle after acceptance; words_done = 0.
REQ-032 FILL dst=0xFFFE, len=3 -> writes at 0xFFFE, 0xFFFF, 0x0000.
REQ-033 Second command held valid during a COPY -> cmd_ready stays 0 until the cycle after done; the second command then runs with its own parameters.
REQ-034 rst_n pulled low in the WRITE of word 2 of a len=5 FILL -> outputs go to reset values asynchronously; exactly 1 word written; the next command executes normally.
